// File: rtl/vme_pkg.sv
// Shared types and constants for the VME slave responder.
package vme_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACCESS,
      ACK,
      ERROR,
      RESCIND,
      WAIT_AS
   } state_e;

   localparam logic [5:0] AM_A24_SUP_DATA  = 6'h3D;
   localparam logic [5:0] AM_A24_USER_DATA = 6'h39;

   function automatic logic am_accepted(input logic [5:0] am, input bit allow_user);
      return (am == AM_A24_SUP_DATA) || (allow_user && (am == AM_A24_USER_DATA));
   endfunction

endpackage

// File: rtl/vme_slave_responder_if.sv
// Backplane and local-bus signals of the VME slave responder.
interface vme_slave_responder_if;

   logic       vme_address_strobe;
   logic       vme_data_strobe_0;
   logic       vme_data_strobe_1;
   logic       vme_write;
   logic [5:0] vme_address_modifier;
   logic [7:0] vme_address_high;

   // Open-collector style lines: the slave supplies level and enable, the pin resolves here
   logic       dtack_drive;
   logic       dtack_enable;
   logic       berr_drive;
   logic       berr_enable;
   wire        vme_dtack;
   wire        vme_berr;

   logic       local_select;
   logic       local_write;
   logic [1:0] local_byte_enable;
   logic       local_ready;

   assign vme_dtack = dtack_enable ? dtack_drive : 1'bz;
   assign vme_berr  = berr_enable  ? berr_drive  : 1'bz;

   modport slave (
      input  vme_address_strobe, vme_data_strobe_0, vme_data_strobe_1, vme_write,
      input  vme_address_modifier, vme_address_high, local_ready,
      output dtack_drive, dtack_enable, berr_drive, berr_enable,
      output local_select, local_write, local_byte_enable
   );

   modport master (
      output vme_address_strobe, vme_data_strobe_0, vme_data_strobe_1, vme_write,
      output vme_address_modifier, vme_address_high, local_ready,
      input  vme_dtack, vme_berr, dtack_drive, dtack_enable, berr_drive, berr_enable,
      input  local_select, local_write, local_byte_enable
   );

endinterface

// File: rtl/vme_input_sync.sv
// Two-flop synchroniser for asynchronous backplane strobes; resets to the inactive level.
module vme_input_sync #(
   parameter int unsigned          WIDTH       = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         meta_q <= RESET_VALUE;
         sync_q <= RESET_VALUE;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/vme_slave_responder.sv
// A24 VME slave: decodes the upper address window, runs a local access and
// terminates the cycle with DTACK*, or BERR* when the local target times out.
module vme_slave_responder
   import vme_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDRESS   = 8'hF0,
   parameter logic [7:0]  ADDRESS_MASK   = 8'hF0,
   parameter bit          ALLOW_USER     = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   vme_slave_responder_if.slave    bus
);

   localparam int unsigned     CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [2:0] strobes_s;
   logic       as_n_s, ds1_n_s, ds0_n_s;
   logic       ds_active, ds_idle, hit;

   vme_input_sync #(
      .WIDTH       (3),
      .RESET_VALUE (3'b111)
   ) u_sync (
      .clock   (clock),
      .reset   (reset),
      .async_i ({bus.vme_address_strobe, bus.vme_data_strobe_1, bus.vme_data_strobe_0}),
      .sync_o  (strobes_s)
   );

   assign {as_n_s, ds1_n_s, ds0_n_s} = strobes_s;
   assign ds_active = !ds0_n_s || !ds1_n_s;
   assign ds_idle   = ds0_n_s && ds1_n_s;
   assign hit = ((bus.vme_address_high & ADDRESS_MASK) == (BASE_ADDRESS & ADDRESS_MASK))
             && am_accepted(bus.vme_address_modifier, ALLOW_USER);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          select_q, select_d;
   logic          write_q, write_d;
   logic [1:0]    be_q, be_d;
   logic          dtack_drive_q, dtack_drive_d, dtack_en_q, dtack_en_d;
   logic          berr_drive_q, berr_drive_d, berr_en_q, berr_en_d;

   // Outputs are registered: each branch sets the levels seen during the next state
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      select_d      = select_q;
      write_d       = write_q;
      be_d          = be_q;
      dtack_drive_d = 1'b1;
      dtack_en_d    = 1'b0;
      berr_drive_d  = 1'b1;
      berr_en_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!as_n_s && ds_active) begin
               if (hit) begin
                  state_d  = ACCESS;
                  count_d  = '0;
                  select_d = 1'b1;
                  write_d  = ~bus.vme_write;
                  be_d     = {~ds1_n_s, ~ds0_n_s};
               end else begin
                  state_d = WAIT_AS;
               end
            end
         end
         ACCESS: begin
            if (ds_idle || bus.local_ready || (count_q == LAST)) begin
               select_d = 1'b0;
               write_d  = 1'b0;
               be_d     = '0;
            end
            if (ds_idle) begin
               state_d = WAIT_AS;
            end else if (bus.local_ready) begin
               state_d       = ACK;
               dtack_en_d    = 1'b1;
               dtack_drive_d = 1'b0;
            end else if (count_q == LAST) begin
               state_d      = ERROR;
               berr_en_d    = 1'b1;
               berr_drive_d = 1'b0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         ACK: begin
            dtack_en_d    = 1'b1;
            dtack_drive_d = ds_idle;
            if (ds_idle) state_d = RESCIND;
         end
         ERROR: begin
            berr_en_d    = 1'b1;
            berr_drive_d = ds_idle;
            if (ds_idle) state_d = RESCIND;
         end
         RESCIND: state_d = WAIT_AS;
         WAIT_AS: if (as_n_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         select_q      <= 1'b0;
         write_q       <= 1'b0;
         be_q          <= '0;
         dtack_drive_q <= 1'b1;
         dtack_en_q    <= 1'b0;
         berr_drive_q  <= 1'b1;
         berr_en_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         select_q      <= select_d;
         write_q       <= write_d;
         be_q          <= be_d;
         dtack_drive_q <= dtack_drive_d;
         dtack_en_q    <= dtack_en_d;
         berr_drive_q  <= berr_drive_d;
         berr_en_q     <= berr_en_d;
      end
   end

   assign bus.local_select      = select_q;
   assign bus.local_write       = write_q;
   assign bus.local_byte_enable = be_q;
   assign bus.dtack_drive       = dtack_drive_q;
   assign bus.dtack_enable      = dtack_en_q;
   assign bus.berr_drive        = berr_drive_q;
   assign bus.berr_enable       = berr_en_q;

endmodule
